rtclock_pps_gen: RTL and testbench

- Transmit side of the PPS interface. Consumes the free-running sec/nsec time produced by the real-time clock and drives a PPS output pulse, once per second, at a programmable nanosecond phase.
- Supplies a reference pulse to external equipment and to downstream test-port timestamp checkers.
- Reports the exact time of each emitted edge and counts missed or skipped seconds caused by time jumps.

---
 rtl/rtclock_pkg.sv | 41 ++++
 rtl/rtclock_pulse_stretch.sv | 58 +++++
 rtl/rtclock_pps_gen.sv | 194 +++++++++++++++++++
 tb/tb_rtclock_pps_gen.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtclock_pkg.sv
// -----------------------------------------------------------------------------
// rtclock_pkg
// Shared definitions for the real-time-clock PPS transmit path.
//   NSEC_MODULO : nanoseconds per second
//   SEC_W       : width of the seconds field
//   NSEC_W      : width of the nanoseconds field
//   pps_state_e : generator states (idle, arm, wait, high)
//   sat_add     : unsigned add that clamps to an all-ones value of a given width
// -----------------------------------------------------------------------------
package rtclock_pkg;

    localparam int unsigned NSEC_MODULO = 1000000000;
    localparam int unsigned SEC_W       = 48;
    localparam int unsigned NSEC_W      = 30;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StWait,
        StHigh
    } pps_state_e;

    // Adds a and b and clamps the result to (2^width - 1). width must be <= SEC_W.
    function automatic logic [SEC_W-1:0] sat_add(
        input logic [SEC_W-1:0] a,
        input logic [SEC_W-1:0] b,
        input int unsigned      width
    );
        logic [SEC_W:0] one;
        logic [SEC_W:0] lim;
        logic [SEC_W:0] sum;
        one = {{SEC_W{1'b0}}, 1'b1};
        lim = (one << width) - one;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > lim) begin
            sum = lim;
        end
        return sum[SEC_W-1:0];
    endfunction

endpackage

// File: rtl/rtclock_pulse_stretch.sv
// -----------------------------------------------------------------------------
// rtclock_pulse_stretch
// Holds the PPS output high for a programmed number of clock cycles.
//   clk_i    : core clock
//   rst_ni   : asynchronous active-low reset
//   load_i   : start a pulse; width_i is captured on this cycle only
//   clear_i  : abort any pulse in progress (takes priority over load_i)
//   width_i  : high time in cycles, 0 is treated as 1
//   pulse_o  : registered pulse output
//   done_o   : high during the last high cycle of a pulse
// -----------------------------------------------------------------------------
module rtclock_pulse_stretch
    import rtclock_pkg::*;
#(
    parameter int unsigned WidthBits = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic                 clear_i,
    input  logic [WidthBits-1:0] width_i,
    output logic                 pulse_o,
    output logic                 done_o
);

    logic [WidthBits-1:0] cnt_q, cnt_d;
    logic                 pulse_q, pulse_d;

    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        if (clear_i) begin
            cnt_d   = '0;
            pulse_d = 1'b0;
        end else if (load_i) begin
            cnt_d   = (width_i == '0) ? WidthBits'(1) : width_i;
            pulse_d = 1'b1;
        end else if (cnt_q != '0) begin
            // Output drops on the edge that takes the count from 1 to 0.
            cnt_d   = cnt_q - WidthBits'(1);
            pulse_d = (cnt_q != WidthBits'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;
    assign done_o  = pulse_q && (cnt_q == WidthBits'(1));

endmodule

// File: rtl/rtclock_pps_gen.sv
// -----------------------------------------------------------------------------
// rtclock_pps_gen
// PPS transmitter: watches the free-running sec/nsec time and raises pps_out once
// per second when nsec first reaches offset_ns, holding it for width_cycles clocks.
// Reports the triggering timestamp and counts seconds lost to forward time jumps.
//
// Ports:
//   clk, resetn        : core clock, asynchronous active-low reset
//   sec, nsec          : current time (same clock domain)
//   enable             : generator enable (level)
//   offset_ns          : rising-edge phase within the second
//   width_cycles       : pulse high time in clocks (0 behaves as 1)
//   period_sec         : seconds between pulses (only with RTCLOCK_PPS_GEN_PERIOD_EN)
//   pps_out, pps_stb   : registered pulse and one-cycle rising-edge strobe
//   pps_sec, pps_nsec  : time sample that triggered the last edge
//   miss_cnt           : saturating count of skipped seconds
//   armed              : generator is waiting for or emitting an edge
//
// Build option: define RTCLOCK_PPS_GEN_PERIOD_EN for pulse-per-N-seconds mode.
// -----------------------------------------------------------------------------
module rtclock_pps_gen
    import rtclock_pkg::*;
#(
    parameter int unsigned C_CLK_TO_NS_RATIO = 8,
    parameter int unsigned C_WIDTH_BITS      = 24,
    parameter int unsigned C_MISS_BITS       = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [SEC_W-1:0]        sec,
    input  logic [NSEC_W-1:0]       nsec,
    input  logic                    enable,
    input  logic [NSEC_W-1:0]       offset_ns,
    input  logic [C_WIDTH_BITS-1:0] width_cycles,
`ifdef RTCLOCK_PPS_GEN_PERIOD_EN
    input  logic [15:0]             period_sec,
`endif
    output logic                    pps_out,
    output logic                    pps_stb,
    output logic [SEC_W-1:0]        pps_sec,
    output logic [NSEC_W-1:0]       pps_nsec,
    output logic [C_MISS_BITS-1:0]  miss_cnt,
    output logic                    armed
);

    // Largest phase that a nsec stepping by C_CLK_TO_NS_RATIO is guaranteed to reach.
    localparam logic [NSEC_W-1:0] LAST_OFFSET = NSEC_W'(NSEC_MODULO - C_CLK_TO_NS_RATIO);

    pps_state_e             state_q, state_d;
    logic [SEC_W-1:0]       target_q, target_d;
    logic                   pps_stb_q, pps_stb_d;
    logic [SEC_W-1:0]       pps_sec_q, pps_sec_d;
    logic [NSEC_W-1:0]      pps_nsec_q, pps_nsec_d;
    logic [C_MISS_BITS-1:0] miss_q, miss_d;
    logic                   armed_q, armed_d;

    logic                   fire;
    logic                   abort;
    logic                   pulse_done;
    logic                   offset_ok;
    logic                   due;
    logic [SEC_W-1:0]       arm_sec;
    logic [SEC_W-1:0]       arm_target;
    logic [SEC_W-1:0]       step;
    logic [SEC_W-1:0]       miss_inc;

    assign offset_ok = (offset_ns <= LAST_OFFSET);
    assign due       = offset_ok && (sec == target_q) && (nsec >= offset_ns);
    // First second whose edge has not yet passed at the arming sample.
    assign arm_sec   = (nsec < offset_ns) ? sec : (sec + SEC_W'(1));

`ifdef RTCLOCK_PPS_GEN_PERIOD_EN
    logic [15:0]      period_q, period_d;
    logic [15:0]      period_in;
    logic [SEC_W-1:0] arm_rem;

    assign period_in  = (period_sec == '0) ? 16'd1 : period_sec;
    // Round the arming second up to the next multiple of the period.
    assign arm_rem    = arm_sec % SEC_W'(period_in);
    assign arm_target = (arm_rem == '0) ? arm_sec : (arm_sec + (SEC_W'(period_in) - arm_rem));
    assign step       = SEC_W'(period_q);
    assign miss_inc   = SEC_W'(1);
`else
    assign arm_target = arm_sec;
    assign step       = SEC_W'(1);
    assign miss_inc   = sec - target_q;
`endif

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        pps_stb_d  = 1'b0;
        pps_sec_d  = pps_sec_q;
        pps_nsec_d = pps_nsec_q;
        miss_d     = miss_q;
        fire       = 1'b0;
        abort      = 1'b0;
`ifdef RTCLOCK_PPS_GEN_PERIOD_EN
        period_d   = period_q;
`endif
        if (!enable) begin
            state_d = StIdle;
            abort   = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StArm;
                end
                StArm: begin
                    target_d = arm_target;
                    state_d  = StWait;
`ifdef RTCLOCK_PPS_GEN_PERIOD_EN
                    period_d = period_in;
`endif
                end
                StWait: begin
                    if (due) begin
                        fire       = 1'b1;
                        pps_stb_d  = 1'b1;
                        pps_sec_d  = sec;
                        pps_nsec_d = nsec;
                        state_d    = StHigh;
`ifdef RTCLOCK_PPS_GEN_PERIOD_EN
                        period_d   = period_in;
`endif
                    end else if (sec > target_q) begin
                        // Time jumped past the target: account for the lost seconds and re-arm.
                        miss_d  = C_MISS_BITS'(sat_add(SEC_W'(miss_q), miss_inc, C_MISS_BITS));
                        state_d = StArm;
                    end else if ((sec + step) < target_q) begin
                        // Time moved backwards: the target is stale, re-arm without counting.
                        state_d = StArm;
                    end
                end
                StHigh: begin
                    // No retrigger while high; a due edge is picked up once back in wait.
                    if (pulse_done) begin
                        target_d = target_q + step;
                        state_d  = StWait;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
        armed_d = (state_d == StWait) || (state_d == StHigh);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            target_q   <= '0;
            pps_stb_q  <= 1'b0;
            pps_sec_q  <= '0;
            pps_nsec_q <= '0;
            miss_q     <= '0;
            armed_q    <= 1'b0;
`ifdef RTCLOCK_PPS_GEN_PERIOD_EN
            period_q   <= 16'd1;
`endif
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            pps_stb_q  <= pps_stb_d;
            pps_sec_q  <= pps_sec_d;
            pps_nsec_q <= pps_nsec_d;
            miss_q     <= miss_d;
            armed_q    <= armed_d;
`ifdef RTCLOCK_PPS_GEN_PERIOD_EN
            period_q   <= period_d;
`endif
        end
    end

    rtclock_pulse_stretch #(
        .WidthBits (C_WIDTH_BITS)
    ) u_stretch (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .load_i  (fire),
        .clear_i (abort),
        .width_i (width_cycles),
        .pulse_o (pps_out),
        .done_o  (pulse_done)
    );

    assign pps_stb  = pps_stb_q;
    assign pps_sec  = pps_sec_q;
    assign pps_nsec = pps_nsec_q;
    assign miss_cnt = miss_q;
    assign armed    = armed_q;

endmodule

// File: tb/tb_rtclock_pps_gen.sv
// -----------------------------------------------------------------------------
// tb_rtclock_pps_gen
// Self-checking bench for rtclock_pps_gen (default build). The bench owns the
// sec/nsec time source; expected edge times come from time arithmetic on the
// offset, expected widths from max(width,1), expected miss counts from a
// saturating sum of skipped seconds.
// -----------------------------------------------------------------------------
module tb_rtclock_pps_gen;

    localparam int unsigned      RATIO      = 8;
    localparam longint unsigned  NS_PER_SEC = 64'd1000000000;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [47:0] sec = '0;
    logic [29:0] nsec = '0;
    logic        enable = 1'b0;
    logic [29:0] offset_ns = '0;
    logic [23:0] width_cycles = '0;
    logic        pps_out;
    logic        pps_stb;
    logic [47:0] pps_sec;
    logic [29:0] pps_nsec;
    logic [15:0] miss_cnt;
    logic        armed;

    int          checks = 0;
    int          errors = 0;
    logic [47:0] prev_sec;
    logic [29:0] prev_nsec;
    longint unsigned exp_miss = 0;

    rtclock_pps_gen #(
        .C_CLK_TO_NS_RATIO (RATIO),
        .C_WIDTH_BITS      (24),
        .C_MISS_BITS       (16)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .sec          (sec),
        .nsec         (nsec),
        .enable       (enable),
        .offset_ns    (offset_ns),
        .width_cycles (width_cycles),
        .pps_out      (pps_out),
        .pps_stb      (pps_stb),
        .pps_sec      (pps_sec),
        .pps_nsec     (pps_nsec),
        .miss_cnt     (miss_cnt),
        .armed        (armed)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ time source
    task automatic set_time(input logic [47:0] s, input logic [29:0] n);
        sec  = s;
        nsec = n;
    endtask

    task automatic advance();
        longint unsigned n;
        n = longint'(nsec) + RATIO;
        if (n >= NS_PER_SEC) begin
            nsec = 30'(n - NS_PER_SEC);
            sec  = sec + 48'd1;
        end else begin
            nsec = 30'(n);
        end
    endtask

    // One clock: the current sample is consumed at the edge, outputs are then
    // stable and the time source moves on to the next sample.
    task automatic tick();
        prev_sec  = sec;
        prev_nsec = nsec;
        @(posedge clk);
        #1;
        advance();
    endtask

    task automatic wait_rise(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (pps_out === 1'b1) seen = 1'b1;
        end
    endtask

    // Called on the first high cycle; returns total high cycles and extra strobes.
    task automatic measure_high(output int len, output int extra_stb);
        bit low_seen;
        len       = 1;
        extra_stb = 0;
        low_seen  = 1'b0;
        for (int i = 0; i < 64 && !low_seen; i++) begin
            tick();
            if (pps_out !== 1'b1) low_seen = 1'b1;
            else len++;
            if (pps_stb === 1'b1) extra_stb++;
        end
    endtask

    // First sample at or after the offset, for samples start, start+RATIO, ...
    function automatic logic [29:0] first_at_or_after(input longint unsigned start,
                                                      input longint unsigned off);
        longint unsigned n;
        n = start;
        if (n < off) n = n + RATIO * ((off - n + RATIO - 1) / RATIO);
        return 30'(n);
    endfunction

    function automatic longint unsigned sat16(input longint unsigned v);
        return (v > 64'd65535) ? 64'd65535 : v;
    endfunction

    // ------------------------------------------------------------ scenarios
    task automatic test_reset();
        #2;
        resetn = 1'b0;
        #8;
        checks++; if (pps_out !== 1'b0) begin errors++; $display("FAIL reset_pps_out: got %b want 0", pps_out); end
        checks++; if (pps_stb !== 1'b0) begin errors++; $display("FAIL reset_pps_stb: got %b want 0", pps_stb); end
        checks++; if (pps_sec !== 48'd0) begin errors++; $display("FAIL reset_pps_sec: got %0d want 0", pps_sec); end
        checks++; if (pps_nsec !== 30'd0) begin errors++; $display("FAIL reset_pps_nsec: got %0d want 0", pps_nsec); end
        checks++; if (miss_cnt !== 16'd0) begin errors++; $display("FAIL reset_miss_cnt: got %0d want 0", miss_cnt); end
        checks++; if (armed !== 1'b0) begin errors++; $display("FAIL reset_armed: got %b want 0", armed); end
        @(negedge clk);
        resetn = 1'b1;
        tick();
        checks++; if (armed !== 1'b0) begin errors++; $display("FAIL reset_idle_armed: got %b want 0", armed); end
    endtask

    task automatic test_basic();
        bit seen;
        int len, extra;
        offset_ns    = 30'd0;
        width_cycles = 24'd4;
        set_time(48'd5, 30'd999999984);
        enable = 1'b1;
        tick();
        tick();
        checks++; if (armed !== 1'b1) begin errors++; $display("FAIL basic_armed: got %b want 1", armed); end
        checks++; if (pps_out !== 1'b0) begin errors++; $display("FAIL basic_early: got %b want 0", pps_out); end
        wait_rise(5, seen);
        checks++; if (!seen) begin errors++; $display("FAIL basic_rise: got no edge want edge"); end
        checks++; if (prev_sec !== 48'd6 || prev_nsec !== 30'd0) begin errors++; $display("FAIL basic_latency: got %0d.%0d want 6.0", prev_sec, prev_nsec); end
        checks++; if (pps_stb !== 1'b1) begin errors++; $display("FAIL basic_stb: got %b want 1", pps_stb); end
        checks++; if (pps_sec !== 48'd6) begin errors++; $display("FAIL basic_pps_sec: got %0d want 6", pps_sec); end
        checks++; if (pps_nsec !== 30'd0) begin errors++; $display("FAIL basic_pps_nsec: got %0d want 0", pps_nsec); end
        measure_high(len, extra);
        checks++; if (len != 4) begin errors++; $display("FAIL basic_width: got %0d want 4", len); end
        checks++; if (extra != 0) begin errors++; $display("FAIL basic_stb_len: got %0d extra want 0", extra); end
    endtask

    task automatic test_offset_width0();
        bit seen;
        int len, extra;
        logic [29:0] exp_n;
        enable = 1'b0;
        tick();
        checks++; if (pps_out !== 1'b0 || armed !== 1'b0) begin errors++; $display("FAIL off_disable: got out=%b armed=%b want 0/0", pps_out, armed); end
        offset_ns    = 30'd500;
        width_cycles = 24'd0;
        set_time(48'd10, 30'd480);
        enable = 1'b1;
        exp_n  = first_at_or_after(480, 500);
        wait_rise(10, seen);
        checks++; if (!seen) begin errors++; $display("FAIL off_rise: got no edge want edge"); end
        checks++; if (prev_nsec !== exp_n) begin errors++; $display("FAIL off_latency: got %0d want %0d", prev_nsec, exp_n); end
        checks++; if (pps_sec !== 48'd10 || pps_nsec !== exp_n) begin errors++; $display("FAIL off_stamp: got %0d.%0d want 10.%0d", pps_sec, pps_nsec, exp_n); end
        measure_high(len, extra);
        checks++; if (len != 1) begin errors++; $display("FAIL off_width0: got %0d want 1", len); end
        set_time(48'd11, 30'd480);
        wait_rise(10, seen);
        checks++; if (!seen) begin errors++; $display("FAIL off_rise2: got no edge want edge"); end
        checks++; if (pps_sec !== 48'd11 || pps_nsec !== exp_n) begin errors++; $display("FAIL off_stamp2: got %0d.%0d want 11.%0d", pps_sec, pps_nsec, exp_n); end
        measure_high(len, extra);
    endtask

    task automatic test_backward_jump();
        bit seen;
        int len, extra;
        offset_ns    = 30'd0;
        width_cycles = 24'd3;
        enable       = 1'b0;
        tick();
        set_time(48'd19, 30'd999999960);
        enable = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (armed !== 1'b1) begin errors++; $display("FAIL back_armed: got %b want 1", armed); end
        set_time(48'd7, 30'd999999960);
        wait_rise(10, seen);
        checks++; if (!seen) begin errors++; $display("FAIL back_rise: got no edge want edge"); end
        checks++; if (pps_sec !== 48'd8 || pps_nsec !== 30'd0) begin errors++; $display("FAIL back_stamp: got %0d.%0d want 8.0", pps_sec, pps_nsec); end
        checks++; if (miss_cnt !== 16'(exp_miss)) begin errors++; $display("FAIL back_miss: got %0d want %0d", miss_cnt, exp_miss); end
        measure_high(len, extra);
        checks++; if (len != 3) begin errors++; $display("FAIL back_width: got %0d want 3", len); end
    endtask

    task automatic test_forward_jump();
        bit seen;
        int len, extra;
        offset_ns    = 30'd0;
        width_cycles = 24'd2;
        enable       = 1'b0;
        tick();
        set_time(48'd19, 30'd999999960);
        enable = 1'b1;
        tick();
        tick();
        tick();
        set_time(48'd23, 30'd0);
        tick();
        exp_miss = sat16(exp_miss + (23 - 20));
        checks++; if (miss_cnt !== 16'(exp_miss)) begin errors++; $display("FAIL fwd_miss: got %0d want %0d", miss_cnt, exp_miss); end
        checks++; if (pps_out !== 1'b0) begin errors++; $display("FAIL fwd_no_pulse: got %b want 0", pps_out); end
        tick();
        set_time(48'd23, 30'd999999960);
        wait_rise(10, seen);
        checks++; if (!seen) begin errors++; $display("FAIL fwd_rise: got no edge want edge"); end
        checks++; if (pps_sec !== 48'd24 || pps_nsec !== 30'd0) begin errors++; $display("FAIL fwd_stamp: got %0d.%0d want 24.0", pps_sec, pps_nsec); end
        measure_high(len, extra);
        checks++; if (len != 2) begin errors++; $display("FAIL fwd_width: got %0d want 2", len); end
        // Next target is second 25; jump far enough to overflow the miss counter.
        set_time(48'd25 + 48'h20000, 30'd0);
        tick();
        exp_miss = sat16(exp_miss + 64'h20000);
        checks++; if (miss_cnt !== 16'(exp_miss)) begin errors++; $display("FAIL fwd_saturate: got %0h want %0h", miss_cnt, exp_miss); end
        checks++; if (pps_out !== 1'b0) begin errors++; $display("FAIL fwd_sat_no_pulse: got %b want 0", pps_out); end
    endtask

    task automatic test_enable_drop();
        bit seen;
        int len, extra;
        offset_ns    = 30'd0;
        width_cycles = 24'd10;
        enable       = 1'b0;
        tick();
        set_time(48'd30, 30'd999999968);
        enable = 1'b1;
        wait_rise(10, seen);
        checks++; if (!seen || pps_sec !== 48'd31) begin errors++; $display("FAIL en_rise: got seen=%b sec=%0d want 1/31", seen, pps_sec); end
        tick();
        checks++; if (pps_out !== 1'b1) begin errors++; $display("FAIL en_cycle2: got %b want 1", pps_out); end
        enable = 1'b0;
        tick();
        checks++; if (pps_out !== 1'b0) begin errors++; $display("FAIL en_drop_out: got %b want 0", pps_out); end
        checks++; if (armed !== 1'b0) begin errors++; $display("FAIL en_drop_armed: got %b want 0", armed); end
        checks++; if (pps_sec !== 48'd31 || pps_nsec !== 30'd0) begin errors++; $display("FAIL en_hold_stamp: got %0d.%0d want 31.0", pps_sec, pps_nsec); end
        checks++; if (miss_cnt !== 16'(exp_miss)) begin errors++; $display("FAIL en_hold_miss: got %0d want %0d", miss_cnt, exp_miss); end
        set_time(48'd31, 30'd999999960);
        enable = 1'b1;
        wait_rise(10, seen);
        checks++; if (!seen || pps_sec !== 48'd32 || pps_nsec !== 30'd0) begin errors++; $display("FAIL en_rearm: got seen=%b %0d.%0d want 1 32.0", seen, pps_sec, pps_nsec); end
        measure_high(len, extra);
        checks++; if (len != 10) begin errors++; $display("FAIL en_width: got %0d want 10", len); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            logic [47:0] s;
            int unsigned off, w, k;
            longint unsigned nstart;
            logic [29:0] exp_n;
            bit late, seen;
            int len, extra;
            s    = {16'($urandom), $urandom} & 48'h7FFF_FFFF_FFFF;
            off  = $urandom_range(999999000, 200);
            w    = $urandom_range(5, 0);
            k    = $urandom_range(12, 3);
            late = 1'($urandom_range(1, 0));
            enable = 1'b0;
            tick();
            offset_ns    = 30'(off);
            width_cycles = 24'(w);
            if (late) begin
                // Arm after this second's edge has passed: the edge belongs to s+1.
                set_time(s, 30'(off + RATIO * $urandom_range(3, 0)));
                enable = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    tick();
                    checks++; if (pps_out !== 1'b0) begin errors++; $display("FAIL rnd_late_early[%0d]: got %b want 0", it, pps_out); end
                end
                s = s + 48'd1;
            end else begin
                enable = 1'b1;
            end
            nstart = longint'(off) - RATIO * k;
            set_time(s, 30'(nstart));
            exp_n = first_at_or_after(nstart, off);
            wait_rise(int'(k) + 4, seen);
            checks++; if (!seen) begin errors++; $display("FAIL rnd_rise[%0d]: got no edge want edge", it); end
            checks++; if (prev_sec !== s || prev_nsec !== exp_n) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d.%0d want %0d.%0d", it, prev_sec, prev_nsec, s, exp_n); end
            checks++; if (pps_stb !== 1'b1) begin errors++; $display("FAIL rnd_stb[%0d]: got %b want 1", it, pps_stb); end
            checks++; if (pps_sec !== s || pps_nsec !== exp_n) begin errors++; $display("FAIL rnd_stamp[%0d]: got %0d.%0d want %0d.%0d", it, pps_sec, pps_nsec, s, exp_n); end
            // A mid-pulse width change must only affect the next pulse.
            width_cycles = 24'($urandom_range(20, 0));
            measure_high(len, extra);
            checks++; if (len != ((w == 0) ? 1 : int'(w))) begin errors++; $display("FAIL rnd_width[%0d]: got %0d want %0d", it, len, (w == 0) ? 1 : w); end
            checks++; if (extra != 0) begin errors++; $display("FAIL rnd_stb_len[%0d]: got %0d extra want 0", it, extra); end
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        offset_ns    = 30'd0;
        width_cycles = 24'd10;
        enable       = 1'b0;
        tick();
        set_time(48'd40, 30'd999999968);
        enable = 1'b1;
        wait_rise(10, seen);
        checks++; if (!seen) begin errors++; $display("FAIL ar_rise: got no edge want edge"); end
        tick();
        tick();
        #3;
        resetn = 1'b0;
        #1;
        exp_miss = 0;
        checks++; if (pps_out !== 1'b0) begin errors++; $display("FAIL ar_pps_out: got %b want 0", pps_out); end
        checks++; if (pps_stb !== 1'b0) begin errors++; $display("FAIL ar_pps_stb: got %b want 0", pps_stb); end
        checks++; if (pps_sec !== 48'd0 || pps_nsec !== 30'd0) begin errors++; $display("FAIL ar_stamp: got %0d.%0d want 0.0", pps_sec, pps_nsec); end
        checks++; if (miss_cnt !== 16'(exp_miss)) begin errors++; $display("FAIL ar_miss: got %0d want 0", miss_cnt); end
        checks++; if (armed !== 1'b0) begin errors++; $display("FAIL ar_armed: got %b want 0", armed); end
        #2;
        resetn = 1'b1;
        tick();
        checks++; if (armed !== 1'b0 || pps_out !== 1'b0) begin errors++; $display("FAIL ar_idle: got armed=%b out=%b want 0/0", armed, pps_out); end
        tick();
        checks++; if (armed !== 1'b1) begin errors++; $display("FAIL ar_rearm: got %b want 1", armed); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_offset_width0();
        test_backward_jump();
        test_forward_jump();
        test_enable_drop();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
